// File: rtl/rf_wport_arb.sv
// rf_wport_arb
//
// Merges two write sources onto the single write port of the RV32I register file
// and tracks which registers are still waiting on a long-latency result.
//
// Write sources:
//   - In-order pipeline writeback. It normally has priority and is never backpressured.
//   - Long-latency results (divider, load-miss unit). They use a valid/ready
//     handshake and are buffered in a small FIFO.
// A starvation counter forces the FIFO head onto the port for one cycle by raising
// wb_stall. The pipeline is then held off.
//
// Ports:
//   clk, reset            clock (rising edge) and async active-high reset
//   p_we, p_rd, p_wd      pipeline writeback request
//   l_valid, l_ready      long-latency result handshake
//   l_rd, l_wd            long-latency result destination/data
//   iss_set, iss_rd       long-latency op dispatched, marks iss_rd busy
//   q1_idx/q1_busy,
//   q2_idx/q2_busy        scoreboard queries (combinational)
//   wb_stall              registered: pipeline must not write back this cycle
//   we3, a3, wd3          register file write port (combinational)
module rf_wport_arb #(
  parameter int XLEN       = 32,
  parameter int IDX_W      = 5,
  parameter int NREG       = 32,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p_we,
  input  logic [IDX_W-1:0] p_rd,
  input  logic [XLEN-1:0]  p_wd,
  input  logic             l_valid,
  output logic             l_ready,
  input  logic [IDX_W-1:0] l_rd,
  input  logic [XLEN-1:0]  l_wd,
  input  logic             iss_set,
  input  logic [IDX_W-1:0] iss_rd,
  input  logic [IDX_W-1:0] q1_idx,
  input  logic [IDX_W-1:0] q2_idx,
  output logic             q1_busy,
  output logic             q2_busy,
  output logic             wb_stall,
  output logic             we3,
  output logic [IDX_W-1:0] a3,
  output logic [XLEN-1:0]  wd3
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
  localparam logic [STV_W-1:0] STV_LAST = STV_W'(STARVE_MAX - 1);

  logic [IDX_W-1:0] rd_mem [QDEPTH];
  logic [XLEN-1:0]  wd_mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;
  logic [NREG-1:0]  busy, busy_next;

  logic empty, full, p_write, sel_fifo, sel_pipe, push, pop, blocked;
  logic [IDX_W-1:0] head_rd;
  logic [XLEN-1:0]  head_wd;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head_rd = rd_mem[rd_ptr];
  assign head_wd = wd_mem[rd_ptr];

  // A write to x0 is not a write, so it leaves the port free for the FIFO.
  assign p_write = p_we && (p_rd != '0);

  // A stall cycle hands the port to the FIFO head.
  // Otherwise the pipeline wins and the FIFO only fills idle slots.
  assign sel_fifo = !empty && (wb_stall || !p_write);
  assign sel_pipe = p_write && !(wb_stall && !empty);
  assign pop      = sel_fifo;
  assign blocked  = !empty && !pop;

  // ready deliberately ignores a same-cycle pop to keep the handshake path short.
  // x0 results complete the handshake but carry nothing worth storing.
  assign l_ready = !full;
  assign push    = l_valid && l_ready && (l_rd != '0);

  // Write port mux. Reset is gated in so the port stays quiet while reset is
  // held, even if the pipeline is still presenting a write.
  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    wd3 = '0;
    if (!reset) begin
      if (sel_fifo) begin
        we3 = 1'b1;
        a3  = head_rd;
        wd3 = head_wd;
      end else if (sel_pipe) begin
        we3 = 1'b1;
        a3  = p_rd;
        wd3 = p_wd;
      end
    end
  end

  // FIFO payload storage. It is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr] <= l_rd;
      wd_mem[wr_ptr] <= l_wd;
    end
  end

  // FIFO pointers and occupancy. QDEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Starvation: after STARVE_MAX consecutive blocked cycles, stall the pipeline
  // for one cycle. The forced pop in that cycle clears the counter again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end else begin
      wb_stall <= blocked && (starve_cnt == STV_LAST);
      if (!blocked || (starve_cnt == STV_LAST)) starve_cnt <= '0;
      else                                      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Scoreboard update. The clear is applied first so that a same-edge issue to
  // the same register keeps it busy. x0 is never busy.
  always_comb begin
    busy_next = busy;
    if (pop)                        busy_next[head_rd] = 1'b0;
    if (iss_set && iss_rd != '0)    busy_next[iss_rd]  = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  assign q1_busy = busy[q1_idx];
  assign q2_busy = busy[q2_idx];

endmodule

// File: tb/tb_rf_wport_arb.sv
// Testbench for rf_wport_arb.
// The stimulus pushes each expected write-port transaction into a queue in the
// cycle it must appear. A separate monitor pops the queue and compares it against
// the port on every falling edge. Other outputs are checked directly.
module tb_rf_wport_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_we, l_valid, l_ready, iss_set;
  logic [4:0]  p_rd, l_rd, iss_rd, q1_idx, q2_idx, a3;
  logic [31:0] p_wd, l_wd, wd3;
  logic        q1_busy, q2_busy, wb_stall, we3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  rf_wport_arb dut (
    .clk(clk), .reset(reset),
    .p_we(p_we), .p_rd(p_rd), .p_wd(p_wd),
    .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_wd(l_wd),
    .iss_set(iss_set), .iss_rd(iss_rd),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .wb_stall(wb_stall), .we3(we3), .a3(a3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                               input logic iss, input logic [4:0] ird);
    p_we = pwe;    p_rd = prd;    p_wd = pwd;
    l_valid = lv;  l_rd = lrd;    l_wd = lwd;
    iss_set = iss; iss_rd = ird;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic expectWrite(input logic [4:0] rd, input logic [31:0] wd);
    wr_t e;
    e.rd = rd;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every expectation is queued for the cycle it is due, so a write with
  // nothing queued and a queued entry with no write are both errors.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (we3) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got a3=%0d wd3=0x%0h, want no write", a3, wd3);
          end else begin
            e = exp_q.pop_front();
            checkOutput("port_a3", {27'd0, a3}, {27'd0, e.rd});
            checkOutput("port_wd3", wd3, e.wd);
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL missing_write: got we3=0, want a3=%0d wd3=0x%0h", e.rd, e.wd);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    wr_t res [10];
    reset = 1'b1;
    idle();
    q1_idx = 5'd0;
    q2_idx = 5'd0;
    repeat (2) @(posedge clk);
    sample();
    checkOutput("rst_we3", {31'd0, we3}, 32'd0);
    checkOutput("rst_l_ready", {31'd0, l_ready}, 32'd1);
    checkOutput("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    checkOutput("rst_q1_busy", {31'd0, q1_busy}, 32'd0);
    nextCycle();
    reset = 1'b0;

    // Pipeline write is zero latency; a write to x0 frees the port.
    nextCycle(); applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectWrite(5'd5, 32'hDEADBEEF);
    sample(); checkOutput("pipe_we3", {31'd0, we3}, 32'd1);
    nextCycle(); applyStimulus(1'b1, 5'd0, 32'h0000CAFE, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    sample(); checkOutput("x0_we3", {31'd0, we3}, 32'd0);

    // Issue rd=7, then return its result while the pipeline is idle.
    q1_idx = 5'd7;
    nextCycle(); applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    sample(); checkOutput("busy7_issue_cycle", {31'd0, q1_busy}, 32'd0);
    nextCycle(); applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
    sample(); checkOutput("busy7_after_issue", {31'd0, q1_busy}, 32'd1);
    checkOutput("l_ready_empty", {31'd0, l_ready}, 32'd1);
    nextCycle(); idle(); expectWrite(5'd7, 32'h1234);
    sample(); checkOutput("busy7_write_cycle", {31'd0, q1_busy}, 32'd1);
    nextCycle(); idle();
    sample(); checkOutput("busy7_cleared", {31'd0, q1_busy}, 32'd0);

    // FIFO fill under continuous pipeline writes, then a forced drain.
    nextCycle(); applyStimulus(1'b1, 5'd10, 32'hA0000000, 1'b1, 5'd11, 32'h0000AAAA, 1'b0, 5'd0);
    expectWrite(5'd10, 32'hA0000000);
    sample(); checkOutput("fill_ready0", {31'd0, l_ready}, 32'd1);
    nextCycle(); applyStimulus(1'b1, 5'd10, 32'hA0000001, 1'b1, 5'd12, 32'h0000BBBB, 1'b0, 5'd0);
    expectWrite(5'd10, 32'hA0000001);
    sample(); checkOutput("fill_ready1", {31'd0, l_ready}, 32'd1);
    nextCycle(); applyStimulus(1'b1, 5'd10, 32'hA0000002, 1'b1, 5'd13, 32'h0000CCCC, 1'b0, 5'd0);
    expectWrite(5'd10, 32'hA0000002);
    sample(); checkOutput("full_ready", {31'd0, l_ready}, 32'd0);
    checkOutput("no_stall_yet", {31'd0, wb_stall}, 32'd0);
    nextCycle(); applyStimulus(1'b1, 5'd10, 32'hA0000003, 1'b1, 5'd13, 32'h0000CCCC, 1'b0, 5'd0);
    expectWrite(5'd10, 32'hA0000003);
    sample(); checkOutput("full_ready_hold", {31'd0, l_ready}, 32'd0);
    nextCycle(); applyStimulus(1'b1, 5'd10, 32'hA0000004, 1'b1, 5'd13, 32'h0000CCCC, 1'b0, 5'd0);
    expectWrite(5'd10, 32'hA0000004);
    sample(); checkOutput("stall_before", {31'd0, wb_stall}, 32'd0);
    nextCycle(); applyStimulus(1'b1, 5'd10, 32'hA0000005, 1'b1, 5'd13, 32'h0000CCCC, 1'b0, 5'd0);
    expectWrite(5'd11, 32'h0000AAAA);
    sample(); checkOutput("stall_high", {31'd0, wb_stall}, 32'd1);
    checkOutput("stall_ready", {31'd0, l_ready}, 32'd0);
    nextCycle(); applyStimulus(1'b1, 5'd10, 32'hA0000006, 1'b1, 5'd13, 32'h0000CCCC, 1'b0, 5'd0);
    expectWrite(5'd10, 32'hA0000006);
    sample(); checkOutput("stall_one_cycle", {31'd0, wb_stall}, 32'd0);
    checkOutput("ready_after_pop", {31'd0, l_ready}, 32'd1);
    nextCycle(); idle(); expectWrite(5'd12, 32'h0000BBBB);
    sample(); checkOutput("refull_ready", {31'd0, l_ready}, 32'd0);
    nextCycle(); idle(); expectWrite(5'd13, 32'h0000CCCC);
    sample(); checkOutput("drain_ready", {31'd0, l_ready}, 32'd1);
    nextCycle(); idle();
    sample(); checkOutput("drained_we3", {31'd0, we3}, 32'd0);

    // Same-edge issue and FIFO write of rd=3: the set wins.
    q2_idx = 5'd3;
    nextCycle(); applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    sample(); checkOutput("busy3_issue_cycle", {31'd0, q2_busy}, 32'd0);
    nextCycle(); applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33330001, 1'b0, 5'd0);
    sample(); checkOutput("busy3_set", {31'd0, q2_busy}, 32'd1);
    nextCycle(); applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    expectWrite(5'd3, 32'h33330001);
    sample(); checkOutput("busy3_write_cycle", {31'd0, q2_busy}, 32'd1);
    nextCycle(); applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33330002, 1'b0, 5'd0);
    sample(); checkOutput("busy3_set_wins", {31'd0, q2_busy}, 32'd1);
    nextCycle(); idle(); expectWrite(5'd3, 32'h33330002);
    sample(); checkOutput("busy3_second_write", {31'd0, q2_busy}, 32'd1);
    nextCycle(); idle();
    sample(); checkOutput("busy3_cleared", {31'd0, q2_busy}, 32'd0);

    // An x0 result is handshaken but never reaches the port.
    nextCycle(); applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h00000BAD, 1'b0, 5'd0);
    sample(); checkOutput("x0_result_ready", {31'd0, l_ready}, 32'd1);
    nextCycle(); idle();
    sample(); checkOutput("x0_result_dropped", {31'd0, we3}, 32'd0);

    // Streaming: push and pop every cycle with one entry resident; order is FIFO.
    for (int i = 0; i < 10; i++) begin
      res[i].rd = 5'($urandom_range(1, 31));
      res[i].wd = $urandom;
    end
    nextCycle(); applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, res[0].rd, res[0].wd, 1'b0, 5'd0);
    sample(); checkOutput("stream_ready_first", {31'd0, l_ready}, 32'd1);
    for (int i = 1; i < 10; i++) begin
      nextCycle(); applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, res[i].rd, res[i].wd, 1'b0, 5'd0);
      expectWrite(res[i-1].rd, res[i-1].wd);
      sample(); checkOutput("stream_ready", {31'd0, l_ready}, 32'd1);
    end
    nextCycle(); idle(); expectWrite(res[9].rd, res[9].wd);
    sample(); checkOutput("stream_ready_last", {31'd0, l_ready}, 32'd1);
    nextCycle(); idle();
    sample(); checkOutput("stream_drained", {31'd0, we3}, 32'd0);

    // Mid-stream reset with two entries queued and x9 busy.
    q1_idx = 5'd9;
    nextCycle(); applyStimulus(1'b1, 5'd1, 32'h11110000, 1'b1, 5'd14, 32'h14141414, 1'b1, 5'd9);
    expectWrite(5'd1, 32'h11110000);
    sample();
    nextCycle(); applyStimulus(1'b1, 5'd1, 32'h11110001, 1'b1, 5'd15, 32'h15151515, 1'b0, 5'd0);
    expectWrite(5'd1, 32'h11110001);
    sample(); checkOutput("busy9_before_reset", {31'd0, q1_busy}, 32'd1);
    nextCycle(); applyStimulus(1'b1, 5'd1, 32'h11110002, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectWrite(5'd1, 32'h11110002);
    sample(); checkOutput("full_before_reset", {31'd0, l_ready}, 32'd0);
    nextCycle(); reset = 1'b1; idle();
    sample();
    checkOutput("midrst_we3", {31'd0, we3}, 32'd0);
    checkOutput("midrst_l_ready", {31'd0, l_ready}, 32'd1);
    checkOutput("midrst_busy9", {31'd0, q1_busy}, 32'd0);
    checkOutput("midrst_wb_stall", {31'd0, wb_stall}, 32'd0);
    nextCycle();
    nextCycle(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nextCycle(); idle();
      sample();
      checkOutput("post_rst_we3", {31'd0, we3}, 32'd0);
      checkOutput("post_rst_busy9", {31'd0, q1_busy}, 32'd0);
    end

    nextCycle();
    checkOutput("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
